// File: rtl/code_entry_fsm_if.sv
// Button-to-comparator link for the code-entry stage.
//   btn          raw push-buttons, active-high, asynchronous to the clock
//   enable       game running; presses are only captured while high
//   clear        synchronous restart of code entry, active-high
//   code_a/b/c   captured slot symbols (0..2)
//   num_inputs   number of slots filled (0..3)
//   code_valid   high while all three slots are filled and released
//   accept_pulse one-cycle pulse per captured symbol
// master: the side driving buttons/controls; slave: the entry FSM.
interface code_entry_fsm_if;
   logic [2:0] btn;
   logic       enable;
   logic       clear;
   logic [1:0] code_a;
   logic [1:0] code_b;
   logic [1:0] code_c;
   logic [1:0] num_inputs;
   logic       code_valid;
   logic       accept_pulse;

   modport master (
      output btn, enable, clear,
      input  code_a, code_b, code_c, num_inputs, code_valid, accept_pulse
   );

   modport slave (
      input  btn, enable, clear,
      output code_a, code_b, code_c, num_inputs, code_valid, accept_pulse
   );
endinterface

// File: rtl/code_entry_fsm.sv
// Code-entry input stage: synchronises and debounces three buttons, turns
// each clean press into a symbol (button i -> symbol i) and fills slots
// A, B, C in order for the three-symbol comparator.
//   clock   system clock
//   resetn  synchronous active-low reset
//   bus     code_entry_fsm_if.slave (buttons/controls in, slots/status out)
module code_entry_fsm #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic                clock,
   input  logic                resetn,
   code_entry_fsm_if.slave     bus
);

   localparam logic [2:0] LOAD_A = 3'd0;
   localparam logic [2:0] WAIT_A = 3'd1;
   localparam logic [2:0] LOAD_B = 3'd2;
   localparam logic [2:0] WAIT_B = 3'd3;
   localparam logic [2:0] LOAD_C = 3'd4;
   localparam logic [2:0] WAIT_C = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0]       sync1_q, sync2_q;
   logic [2:0]       deb_q, deb_d, deb_prev_q;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];

   logic [2:0] state_q, state_d;
   logic [1:0] code_a_q, code_a_d;
   logic [1:0] code_b_q, code_b_d;
   logic [1:0] code_c_q, code_c_d;
   logic [1:0] num_q, num_d;
   logic       acc_q, acc_d;

   logic [2:0] press;
   logic       single;
   logic [1:0] sym;
   logic       all_released;

   // Counter runs only while the synchronised level disagrees with the
   // accepted level; any agreement restarts the stability window.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         deb_d[i] = deb_q[i];
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Exactly one rising edge is required; simultaneous presses are ambiguous.
   always_comb begin
      press        = deb_q & ~deb_prev_q;
      single       = (press != 3'b000) && ((press & (press - 3'd1)) == 3'b000);
      sym          = press[0] ? 2'd0 : (press[1] ? 2'd1 : 2'd2);
      all_released = (deb_q == 3'b000);
   end

   always_comb begin
      state_d  = state_q;
      code_a_d = code_a_q;
      code_b_d = code_b_q;
      code_c_d = code_c_q;
      num_d    = num_q;
      acc_d    = 1'b0;
      if (bus.clear) begin
         state_d  = LOAD_A;
         code_a_d = 2'd0;
         code_b_d = 2'd0;
         code_c_d = 2'd0;
         num_d    = 2'd0;
      end else begin
         case (state_q)
            LOAD_A: if (bus.enable && single) begin
               code_a_d = sym;
               num_d    = 2'd1;
               acc_d    = 1'b1;
               state_d  = WAIT_A;
            end
            WAIT_A: if (all_released) state_d = LOAD_B;
            LOAD_B: if (bus.enable && single) begin
               code_b_d = sym;
               num_d    = 2'd2;
               acc_d    = 1'b1;
               state_d  = WAIT_B;
            end
            WAIT_B: if (all_released) state_d = LOAD_C;
            LOAD_C: if (bus.enable && single) begin
               code_c_d = sym;
               num_d    = 2'd3;
               acc_d    = 1'b1;
               state_d  = WAIT_C;
            end
            WAIT_C: if (all_released) state_d = DONE;
            DONE:   state_d = DONE;
            default: state_d = LOAD_A;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
         state_q    <= LOAD_A;
         code_a_q   <= '0;
         code_b_q   <= '0;
         code_c_q   <= '0;
         num_q      <= '0;
         acc_q      <= 1'b0;
      end else begin
         sync1_q    <= bus.btn;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
         state_q    <= state_d;
         code_a_q   <= code_a_d;
         code_b_q   <= code_b_d;
         code_c_q   <= code_c_d;
         num_q      <= num_d;
         acc_q      <= acc_d;
      end
   end

   assign bus.code_a       = code_a_q;
   assign bus.code_b       = code_b_q;
   assign bus.code_c       = code_c_q;
   assign bus.num_inputs   = num_q;
   assign bus.accept_pulse = acc_q;
   assign bus.code_valid   = (state_q == DONE);

endmodule

// File: tb/tb_code_entry_fsm.sv
// Bench for code_entry_fsm with a short debounce window.
module tb_code_entry_fsm;
   localparam int D = 4;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   code_entry_fsm_if ifc ();

   code_entry_fsm #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (ifc)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: a button level is accepted once the last D samples
   // (delayed two edges by the synchroniser) all disagree with it. Entry is
   // tracked as a fill count plus a waiting-for-release flag.
   logic [2:0] hist[$];
   logic [2:0] mdeb  = '0;
   logic [2:0] mprev = '0;
   logic [1:0] ms[3];
   logic [1:0] mn    = '0;
   bit         mwait = 0;
   bit         macc  = 0;

   function automatic logic [9:0] model_out();
      return {ms[0], ms[1], ms[2], mn, (mn == 2'd3) && !mwait, macc};
   endfunction

   task automatic model_update();
      logic [2:0] rise;
      logic [2:0] smp;
      logic [1:0] sym;
      int sz;
      bit diff;
      smp = ifc.btn;
      if (!resetn) begin
         foreach (hist[k]) hist[k] = 3'b000;
         hist.push_back(3'b000);
         mdeb = '0; mprev = '0; mn = '0; mwait = 0; macc = 0;
         for (int s = 0; s < 3; s++) ms[s] = '0;
         return;
      end
      rise = mdeb & ~mprev;
      sym  = rise[0] ? 2'd0 : (rise[1] ? 2'd1 : 2'd2);
      macc = 0;
      if (ifc.clear) begin
         mn = '0; mwait = 0;
         for (int s = 0; s < 3; s++) ms[s] = '0;
      end else if (mwait) begin
         if (mdeb == 3'b000) mwait = 0;
      end else if (mn < 2'd3 && ifc.enable && $countones(rise) == 1) begin
         ms[mn] = sym;
         mn     = mn + 2'd1;
         mwait  = 1;
         macc   = 1;
      end
      mprev = mdeb;
      sz = hist.size();
      for (int i = 0; i < 3; i++) begin
         diff = 1;
         for (int k = sz - D - 1; k <= sz - 2; k++)
            if (hist[k][i] == mdeb[i]) diff = 0;
         if (diff) mdeb[i] = ~mdeb[i];
      end
      hist.push_back(smp);
   endtask

   task automatic step();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic drive(input logic [2:0] v, input int hold, input int gap);
      ifc.btn = v;
      repeat (hold) step();
      ifc.btn = 3'b000;
      repeat (gap) step();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int c = 0; c < 3; c++) begin
         ifc.btn = 3'($urandom_range(7, 0));
         step();
         n_cmp++;
         if ({ifc.code_a, ifc.code_b, ifc.code_c, ifc.num_inputs, ifc.code_valid, ifc.accept_pulse} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got=%b want=%b", c,
               {ifc.code_a, ifc.code_b, ifc.code_c, ifc.num_inputs, ifc.code_valid, ifc.accept_pulse}, 10'd0);
         end
      end
      ifc.btn = 3'b000;
      resetn  = 1'b1;
      step();
      n_cmp++;
      if (ifc.num_inputs !== 2'd0 || ifc.code_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release got num=%0d valid=%b want num=0 valid=0", ifc.num_inputs, ifc.code_valid);
      end
      repeat (8) step();
   endtask

   task automatic test_glitch();
      ifc.btn = 3'b010;
      for (int c = 0; c < 13; c++) begin
         if (c == 3) ifc.btn = 3'b000;
         step();
         n_cmp++;
         if (ifc.accept_pulse !== 1'b0 || ifc.accept_pulse !== macc) begin
            n_fail++;
            $display("FAIL glitch_accept cyc=%0d got=%b want=0", c, ifc.accept_pulse);
         end
      end
      n_cmp++;
      if (ifc.num_inputs !== 2'd0) begin
         n_fail++;
         $display("FAIL glitch_num got=%0d want=0", ifc.num_inputs);
      end
   endtask

   task automatic test_full_entry();
      logic [2:0] seq[3];
      int lat;
      seq[0] = 3'b100; seq[1] = 3'b001; seq[2] = 3'b010;
      for (int p = 0; p < 3; p++) begin
         lat = -1;
         for (int k = 0; k < 20; k++) begin
            ifc.btn = (k < 10) ? seq[p] : 3'b000;
            step();
            n_cmp++;
            if (ifc.accept_pulse !== macc) begin
               n_fail++;
               $display("FAIL entry_accept p=%0d k=%0d got=%b want=%b", p, k, ifc.accept_pulse, macc);
            end
            if (ifc.accept_pulse === 1'b1) lat = k;
         end
         n_cmp++;
         if (lat != D + 2) begin
            n_fail++;
            $display("FAIL entry_latency p=%0d got=%0d want=%0d", p, lat, D + 2);
         end
      end
      n_cmp++;
      if (ifc.code_a !== 2'd2 || ifc.code_b !== 2'd0 || ifc.code_c !== 2'd1 ||
          ifc.num_inputs !== 2'd3 || ifc.code_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL entry_result got a=%0d b=%0d c=%0d n=%0d v=%b want a=2 b=0 c=1 n=3 v=1",
            ifc.code_a, ifc.code_b, ifc.code_c, ifc.num_inputs, ifc.code_valid);
      end
   endtask

   task automatic test_restart();
      ifc.clear = 1'b1;
      step();
      ifc.clear = 1'b0;
      n_cmp++;
      if ({ifc.code_a, ifc.code_b, ifc.code_c, ifc.num_inputs, ifc.code_valid, ifc.accept_pulse} !== 10'd0) begin
         n_fail++;
         $display("FAIL clear_done got=%b want=%b",
            {ifc.code_a, ifc.code_b, ifc.code_c, ifc.num_inputs, ifc.code_valid, ifc.accept_pulse}, 10'd0);
      end
      drive(3'b001, 10, 10);
      drive(3'b100, 9, 0);        // captured, still held: sitting in WAIT_B
      n_cmp++;
      if (ifc.num_inputs !== 2'd2 || ifc.code_b !== 2'd2) begin
         n_fail++;
         $display("FAIL waitb_setup got n=%0d b=%0d want n=2 b=2", ifc.num_inputs, ifc.code_b);
      end
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      n_cmp++;
      if ({ifc.code_a, ifc.code_b, ifc.code_c, ifc.num_inputs, ifc.code_valid} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_waitb got=%b want=%b",
            {ifc.code_a, ifc.code_b, ifc.code_c, ifc.num_inputs, ifc.code_valid}, 9'd0);
      end
      drive(3'b000, 0, 10);
      drive(3'b010, 10, 10);
      n_cmp++;
      if (ifc.code_a !== 2'd1 || ifc.num_inputs !== 2'd1) begin
         n_fail++;
         $display("FAIL after_reset_loada got a=%0d n=%0d want a=1 n=1", ifc.code_a, ifc.num_inputs);
      end
   endtask

   task automatic test_release_gating();
      ifc.clear = 1'b1;
      step();
      ifc.clear = 1'b0;
      drive(3'b001, 8, 0);
      drive(3'b011, 10, 10);
      n_cmp++;
      if (ifc.num_inputs !== 2'd1 || ifc.code_a !== 2'd0) begin
         n_fail++;
         $display("FAIL gating_hold got n=%0d a=%0d want n=1 a=0", ifc.num_inputs, ifc.code_a);
      end
      drive(3'b010, 10, 10);
      n_cmp++;
      if (ifc.num_inputs !== 2'd2 || ifc.code_b !== 2'd1) begin
         n_fail++;
         $display("FAIL gating_next got n=%0d b=%0d want n=2 b=1", ifc.num_inputs, ifc.code_b);
      end
   endtask

   task automatic test_ambiguous_enable();
      ifc.clear = 1'b1;
      step();
      ifc.clear = 1'b0;
      ifc.btn = 3'b011;
      for (int c = 0; c < 20; c++) begin
         if (c == 10) ifc.btn = 3'b000;
         step();
         n_cmp++;
         if (ifc.accept_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL ambiguous_accept cyc=%0d got=%b want=0", c, ifc.accept_pulse);
         end
      end
      ifc.enable = 1'b0;
      ifc.btn    = 3'b100;
      for (int c = 0; c < 30; c++) begin
         if (c == 10) ifc.btn = 3'b000;
         if (c == 20) ifc.enable = 1'b1;
         step();
         n_cmp++;
         if (ifc.accept_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_accept cyc=%0d got=%b want=0", c, ifc.accept_pulse);
         end
      end
      n_cmp++;
      if (ifc.num_inputs !== 2'd0 || ifc.code_a !== 2'd0) begin
         n_fail++;
         $display("FAIL ambig_enable_state got n=%0d a=%0d want n=0 a=0", ifc.num_inputs, ifc.code_a);
      end
      drive(3'b001, 10, 10);
      n_cmp++;
      if (ifc.num_inputs !== 2'd1 || ifc.code_a !== 2'd0) begin
         n_fail++;
         $display("FAIL enable_resume got n=%0d a=%0d want n=1 a=0", ifc.num_inputs, ifc.code_a);
      end
   endtask

   task automatic test_random();
      int hold;
      for (int seg = 0; seg < 120; seg++) begin
         case ($urandom_range(3, 0))
            0: ifc.btn = 3'b000;
            1, 2: ifc.btn = 3'(1 << $urandom_range(2, 0));
            default: ifc.btn = 3'($urandom_range(7, 0));
         endcase
         ifc.enable = ($urandom_range(7, 0) != 0);
         hold = $urandom_range(9, 1);
         for (int c = 0; c < hold; c++) begin
            ifc.clear = ($urandom_range(39, 0) == 0);
            resetn    = ($urandom_range(79, 0) != 0);
            step();
            n_cmp++;
            if ({ifc.code_a, ifc.code_b, ifc.code_c, ifc.num_inputs, ifc.code_valid, ifc.accept_pulse} !== model_out()) begin
               n_fail++;
               $display("FAIL random seg=%0d cyc=%0d got=%b want=%b", seg, c,
                  {ifc.code_a, ifc.code_b, ifc.code_c, ifc.num_inputs, ifc.code_valid, ifc.accept_pulse}, model_out());
            end
         end
      end
      ifc.clear = 1'b0;
      resetn    = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < D + 2; k++) hist.push_back(3'b000);
      for (int s = 0; s < 3; s++) ms[s] = '0;
      ifc.btn    = 3'b000;
      ifc.enable = 1'b1;
      ifc.clear  = 1'b0;
      resetn     = 1'b0;
      #1;
      test_reset();
      test_glitch();
      test_full_entry();
      test_restart();
      test_release_gating();
      test_ambiguous_enable();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/code_entry_fsm.md
Name: code_entry_fsm

Overview:
- Upstream input stage of the code-guessing game; sits between the GPIO push-buttons and the three-symbol comparator.
- Synchronises and debounces three raw buttons, then converts each press into a 2-bit symbol (button i gives symbol i, range 0..2).
- Fills three code slots in order (A, B, C) and presents them, with a valid flag, to the comparator inputs that are currently driven by SW[13:12], SW[15:14] and SW[17:16].

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz).
- CNT_W, 19: width of each per-button debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level)
- resetn  in  1  synchronous, active-low reset
- btn  in  3  raw GPIO buttons, active-high, asynchronous to clock
- enable  in  1  game running; when low, presses are not captured
- clear  in  1  synchronous restart of entry, active-high
- code_a  out  2  slot A symbol
- code_b  out  2  slot B symbol
- code_c  out  2  slot C symbol
- num_inputs  out  2  number of slots filled, 0..3
- code_valid  out  1  high while all three slots are filled
- accept_pulse  out  1  one-cycle pulse on each captured symbol

Behaviour:
- Reset (resetn=0 at a clock edge): all outputs are 0, state is LOAD_A, synchroniser and debounced levels are 0, and counters are 0. Reset mid-sequence discards partial entry.
- Synchroniser: 2 flops per button. No combinational path from btn.
- Debounce, per button:
  - The counter increments while the synchronised level differs from the debounced level, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, the debounced level toggles and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES are never seen.
- Press event: debounced level rising (1 now, 0 previous cycle); one cycle per press.
- Latency: btn first sampled high at edge N and held → accept_pulse and slot update are registered at edge N+DEBOUNCE_CYCLES+2, exactly.
- FSM states:
  - LOAD_A: a single press event, with enable=1, writes its symbol to code_a, sets num_inputs=1, pulses accept_pulse, and moves to WAIT_A.
  - WAIT_A: stays until all three debounced levels are 0, then moves to LOAD_B.
  - LOAD_B / WAIT_B: same as A, writing code_b and setting num_inputs=2.
  - LOAD_C / WAIT_C: same as A, writing code_c and setting num_inputs=3; WAIT_C then moves to DONE.
  - DONE: code_valid=1 and slots held; stays until clear.
- Boundary rules:
  - Two or more press events in the same cycle are ambiguous: ignored entirely, with no slot write and no state change.
  - Press events in WAIT_x or DONE are ignored.
  - enable=0: no captures, state and slots hold, debouncers keep running. A press completing while enable=0 is lost and is not replayed.
  - clear=1 in any state: next edge gives LOAD_A, slots 0, num_inputs 0, code_valid 0, accept_pulse 0. clear beats a simultaneous press.
  - resetn beats clear.
- code_valid is combinationally derived from state==DONE, or registered equivalently. The encoded value is unreachable for button index 3 (not present).
- Symbols are always 0..2, so the comparator's symbol%3 matching is unaffected.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold resetn=0 for 3 cycles, btn random → all outputs 0; after release, num_inputs=0 and code_valid=0.
- Glitch reject: btn[1]=1 for 3 cycles, then 0 → no accept_pulse, num_inputs=0.
- Full entry: press/release btn[2], btn[0], btn[1], each held 10 cycles with a 10-cycle gap.
  - accept_pulse appears 3 times, each at N+6.
  - Result: code_a=2, code_b=0, code_c=1, num_inputs=3, code_valid=1.
- Release gating: hold btn[0] high, then also press btn[1] → num_inputs stays 1 and code_a=0. After both release, pressing btn[1] gives code_b=1.
- Ambiguity and enable:
  - btn[0] and btn[1] rising on the same cycle → nothing captured.
  - With enable=0, press btn[2] → nothing captured, state stays LOAD_A.
- Restart: in DONE assert clear for 1 cycle → next cycle slots 0, num_inputs 0, code_valid 0. Also assert resetn=0 mid-way through WAIT_B → state LOAD_A and all slots 0.
